// File: rtl/half_adder_pkg.sv
// Shared types and helpers for the half-adder response checker.
package half_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    localparam int ERR_VEC_W = 4;

    // Golden half-adder response packed as {sum, carry}.
    function automatic logic [1:0] expected_result(input logic a, input logic b);
        return {a ^ b, a & b};
    endfunction

endpackage

// File: rtl/half_adder_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/half_adder_checker.sv
// Response checker for a half adder: waits for a stable {a,b}, then compares
// sum/carry once per stable vector, counting vectors, errors and coverage.
module half_adder_checker
    import half_adder_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear,
    input  logic                 a,
    input  logic                 b,
    input  logic                 sum,
    input  logic                 carry,
    output logic [CNT_W-1:0]     vec_count,
    output logic [CNT_W-1:0]     err_count,
    output logic                 err_flag,
    output logic                 first_err_valid,
    output logic [ERR_VEC_W-1:0] first_err_vec,
    output logic [3:0]           cov,
    output logic                 all_covered,
    output logic                 check_pulse
);

    localparam logic [4:0] SETTLE_L = 5'(SETTLE);
    // With a one-cycle window a freshly latched vector is already settled.
    localparam state_t ENTER_ST = (SETTLE == 1) ? S_CHECK : S_SETTLE;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [1:0]           prev_ab_q, prev_ab_d;
    logic                 prev_valid_q, prev_valid_d;
    logic                 err_flag_q, err_flag_d;
    logic                 fev_valid_q, fev_valid_d;
    logic [ERR_VEC_W-1:0] fev_q, fev_d;
    logic [3:0]           cov_q, cov_d;
    logic                 check_pulse_q, check_pulse_d;

    logic [1:0] ab;
    logic [1:0] obs;
    logic       changed;
    logic       mismatch;
    logic       do_check;
    logic [4:0] cnt_inc;

    assign ab       = {a, b};
    assign obs      = {sum, carry};
    assign changed  = !prev_valid_q || (ab != prev_ab_q);
    assign mismatch = (obs != expected_result(a, b));
    assign do_check = (state_q == S_CHECK) && en && !clear;
    assign cnt_inc  = {1'b0, cnt_q} + 5'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prev_ab_d    = prev_ab_q;
        prev_valid_d = prev_valid_q;
        err_flag_d   = err_flag_q;
        fev_valid_d  = fev_valid_q;
        fev_d        = fev_q;
        cov_d        = cov_q;
        if (clear) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            prev_ab_d    = '0;
            prev_valid_d = 1'b0;
            err_flag_d   = 1'b0;
            fev_valid_d  = 1'b0;
            fev_d        = '0;
            cov_d        = '0;
        end else if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d      = ENTER_ST;
                    cnt_d        = 4'd1;
                    prev_ab_d    = ab;
                    prev_valid_d = 1'b1;
                end
                S_SETTLE: begin
                    if (changed) begin
                        state_d      = ENTER_ST;
                        cnt_d        = 4'd1;
                        prev_ab_d    = ab;
                        prev_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc[3:0];
                        if (cnt_inc >= SETTLE_L) begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    state_d    = S_WAIT;
                    cov_d[ab]  = 1'b1;
                    if (mismatch) begin
                        err_flag_d = 1'b1;
                        if (!fev_valid_q) begin
                            fev_valid_d = 1'b1;
                            fev_d       = {ab, obs};
                        end
                    end
                end
                default: begin
                    if (changed) begin
                        state_d      = ENTER_ST;
                        cnt_d        = 4'd1;
                        prev_ab_d    = ab;
                        prev_valid_d = 1'b1;
                    end
                end
            endcase
        end
        check_pulse_d = (state_d == S_CHECK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            prev_ab_q     <= '0;
            prev_valid_q  <= 1'b0;
            err_flag_q    <= 1'b0;
            fev_valid_q   <= 1'b0;
            fev_q         <= '0;
            cov_q         <= '0;
            check_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prev_ab_q     <= prev_ab_d;
            prev_valid_q  <= prev_valid_d;
            err_flag_q    <= err_flag_d;
            fev_valid_q   <= fev_valid_d;
            fev_q         <= fev_d;
            cov_q         <= cov_d;
            check_pulse_q <= check_pulse_d;
        end
    end

    // Error counter only advances alongside the vector counter.
    sat_counter #(.W(CNT_W)) u_vec_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (do_check),
        .q   (vec_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (do_check && mismatch),
        .q   (err_count)
    );

    assign err_flag        = err_flag_q;
    assign first_err_valid = fev_valid_q;
    assign first_err_vec   = fev_q;
    assign cov             = cov_q;
    assign all_covered     = &cov_q;
    assign check_pulse     = check_pulse_q;

endmodule

// File: tb/tb_half_adder_checker.sv
// Directed bench for half_adder_checker with a behavioural half adder whose
// faults can be selected; a scoreboard predicts every compare strobe.
module tb_half_adder_checker;

    localparam int CNT_W  = 16;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en, clear, a, b, sum, carry;
    int   mode;

    logic [CNT_W-1:0] vec_count, err_count;
    logic             err_flag, first_err_valid, all_covered, check_pulse;
    logic [3:0]       first_err_vec, cov;

    logic [2:0] vec_count3, err_count3;
    logic       err_flag3, first_err_valid3, all_covered3, check_pulse3;
    logic [3:0] first_err_vec3, cov3;

    typedef struct {
        logic [3:0] vec;
        int         exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode 0: good adder; 1: OR gate for sum, carry stuck low; 2: inverted sum
    function automatic logic [1:0] model_out(input int m, input logic [1:0] ab);
        case (m)
            1:       return {ab[1] | ab[0], 1'b0};
            2:       return {~(ab[1] ^ ab[0]), ab[1] & ab[0]};
            default: return {ab[1] ^ ab[0], ab[1] & ab[0]};
        endcase
    endfunction

    always_comb begin
        {sum, carry} = 2'b00;
        {sum, carry} = model_out(mode, {a, b});
    end

    half_adder_checker #(.CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .clear           (clear),
        .a               (a),
        .b               (b),
        .sum             (sum),
        .carry           (carry),
        .vec_count       (vec_count),
        .err_count       (err_count),
        .err_flag        (err_flag),
        .first_err_valid (first_err_valid),
        .first_err_vec   (first_err_vec),
        .cov             (cov),
        .all_covered     (all_covered),
        .check_pulse     (check_pulse)
    );

    half_adder_checker #(.CNT_W(3), .SETTLE(SETTLE)) dut3 (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .clear           (clear),
        .a               (a),
        .b               (b),
        .sum             (sum),
        .carry           (carry),
        .vec_count       (vec_count3),
        .err_count       (err_count3),
        .err_flag        (err_flag3),
        .first_err_valid (first_err_valid3),
        .first_err_vec   (first_err_vec3),
        .cov             (cov3),
        .all_covered     (all_covered3),
        .check_pulse     (check_pulse3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a vector now; when push is set the compare strobe is predicted SETTLE cycles later.
    task automatic apply(input logic [1:0] ab, input int hold, input bit push);
        exp_t e;
        a = ab[1];
        b = ab[0];
        if (push) begin
            e.vec     = {ab, model_out(mode, ab)};
            e.exp_cyc = cyc + SETTLE;
            sb.push_back(e);
        end
        step(hold);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && check_pulse) begin
            if (sb.size() == 0) begin
                chk("unexpected_check", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("check_cycle", cyc, e.exp_cyc);
                chk("check_vec", {28'd0, a, b, sum, carry}, {28'd0, e.vec});
            end
        end
    end

    initial begin
        en    = 1'b0;
        clear = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        mode  = 0;
        #2 rst = 1'b1;
        step(2);
        chk("rst_vec_count", vec_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_fev_valid", first_err_valid, 0);
        chk("rst_fev", first_err_vec, 0);
        chk("rst_cov", cov, 0);
        chk("rst_all_cov", all_covered, 0);
        chk("rst_pulse", check_pulse, 0);
        chk("rst_dut3", {vec_count3, err_count3, err_flag3, first_err_valid3,
                         first_err_vec3, cov3, all_covered3, check_pulse3}, 0);
        rst = 1'b0;
        en  = 1'b1;

        // all four vectors against a good adder
        apply(2'b00, 4, 1);
        apply(2'b01, 4, 1);
        apply(2'b10, 4, 1);
        apply(2'b11, 4, 1);
        chk("good_vec_count", vec_count, 4);
        chk("good_err_count", err_count, 0);
        chk("good_err_flag", err_flag, 0);
        chk("good_fev_valid", first_err_valid, 0);
        chk("good_cov", cov, 4'b1111);
        chk("good_all_cov", all_covered, 1);

        // first failure is captured
        apply(2'b00, 4, 1);
        mode = 1;
        apply(2'b11, 4, 1);
        chk("f1_vec_count", vec_count, 6);
        chk("f1_err_count", err_count, 1);
        chk("f1_err_flag", err_flag, 1);
        chk("f1_fev_valid", first_err_valid, 1);
        chk("f1_fev", first_err_vec, 4'b1110);

        // a later failure counts but leaves the capture alone
        mode = 2;
        apply(2'b01, 4, 1);
        chk("f2_vec_count", vec_count, 7);
        chk("f2_err_count", err_count, 2);
        chk("f2_fev", first_err_vec, 4'b1110);

        // clear, then a never-stable input, then a held vector
        mode  = 0;
        clear = 1'b1;
        a     = 1'b0;
        b     = 1'b0;
        step(1);
        clear = 1'b0;
        chk("clr_vec_count", vec_count, 0);
        chk("clr_err_count", err_count, 0);
        chk("clr_err_flag", err_flag, 0);
        chk("clr_fev_valid", first_err_valid, 0);
        chk("clr_cov", cov, 0);
        for (int i = 0; i < 9; i++) begin
            apply((i % 2 == 0) ? 2'b11 : 2'b00, 1, 0);
        end
        chk("toggle_vec_count", vec_count, 0);
        apply(2'b10, 5, 1);
        chk("hold_vec_count", vec_count, 1);
        chk("hold_cov", cov, 4'b0100);

        // saturation of the narrow instance
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        for (int i = 0; i < 9; i++) begin
            apply(2'(i % 4), 4, 1);
        end
        chk("sat_vec_count16", vec_count, 9);
        chk("sat_vec_count3", vec_count3, 7);
        chk("sat_err_count3", err_count3, 0);
        chk("sat_all_cov3", all_covered3, 1);

        // clear in the CHECK cycle wins over the update
        apply(2'b01, 2, 1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clrchk_vec_count", vec_count, 0);
        chk("clrchk_cov", cov, 0);
        chk("clrchk_vec_count3", vec_count3, 0);
        apply(2'b01, 4, 1);
        chk("recheck_vec_count", vec_count, 1);
        chk("recheck_cov", cov, 4'b0010);

        // asynchronous reset while settling
        apply(2'b11, 1, 0);
        rst = 1'b1;
        #1;
        chk("arst_vec_count", vec_count, 0);
        chk("arst_cov", cov, 0);
        chk("arst_pulse", check_pulse, 0);
        chk("arst_vec_count3", vec_count3, 0);
        step(1);
        rst = 1'b0;
        apply(2'b11, 4, 1);
        chk("post_rst_vec_count", vec_count, 1);
        chk("post_rst_cov", cov, 4'b1000);

        // enable dropped while settling, then restored
        apply(2'b00, 1, 0);
        en = 1'b0;
        step(4);
        chk("en_drop_vec_count", vec_count, 1);
        chk("en_drop_pulse", check_pulse, 0);
        en = 1'b1;
        apply(2'b00, 4, 1);
        chk("en_rise_vec_count", vec_count, 2);
        chk("en_rise_cov", cov, 4'b1001);

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/half_adder_checker.md
Name: half_adder_checker

Overview:
- Synthesizable response checker for the other end of the half-adder interface. It observes the stimulus pair (a, b) and the DUT outputs (sum, carry).
- After the stimulus has been stable for a programmed settle window, it checks `sum == a^b` and `carry == a&b`.
- It counts vectors and errors, captures the first failing vector, and tracks coverage of the four input combinations.
- It sits beside a half_adder instance in on-chip self-test or FPGA bring-up, replacing waveform inspection.

Parameters:
- CNT_W, 16, width of the vector and error counters (saturating).
- SETTLE, 2, number of consecutive cycles {a,b} must hold before a compare; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  checker enable; low holds the FSM in IDLE.
- clear  input  1  synchronous clear of counters, flags, capture and coverage.
- a  input  1  stimulus bit a, synchronous to clk.
- b  input  1  stimulus bit b, synchronous to clk.
- sum  input  1  DUT sum output.
- carry  input  1  DUT carry output.
- vec_count  output  CNT_W  number of vectors compared.
- err_count  output  CNT_W  number of mismatching vectors.
- err_flag  output  1  sticky; set on the first mismatch.
- first_err_valid  output  1  first_err_vec holds a captured vector.
- first_err_vec  output  4  {a,b,sum,carry} of the first mismatch.
- cov  output  4  bit i set once input pair {a,b}==i has been checked.
- all_covered  output  1  equals &cov.
- check_pulse  output  1  one-cycle strobe on each compare.

Behaviour:
- Reset (async, rst high):
  - All outputs are 0.
  - State is IDLE, settle counter is 0, and the prev_ab register is 0 with prev_valid=0.
- States:
  - IDLE: entered from reset, from clear, or whenever en=0. Moves to SETTLE on the first cycle en=1; the settle counter loads 1 and prev_ab is latched.
  - SETTLE: each cycle, if {a,b}!=prev_ab, latch the new value and reload the counter to 1 (restart). Otherwise increment the counter. When the counter reaches SETTLE and {a,b} is still unchanged, go to CHECK.
  - CHECK: lasts exactly one cycle.
    - check_pulse=1 and vec_count increments.
    - cov[{a,b}] is set.
    - If sum!=(a^b) or carry!=(a&b): err_count increments and err_flag is set. If first_err_valid=0, first_err_vec and first_err_valid are loaded.
    - Next state is WAIT.
  - WAIT: stays until {a,b}!=prev_ab, then latches and enters SETTLE with the counter at 1. Each stable vector is therefore checked exactly once.
- Latency: a vector applied at cycle t, stable through t+SETTLE-1, produces check_pulse at t+SETTLE. Counters are visible at t+SETTLE+1.
- DUT sum/carry are sampled only in CHECK; glitches during SETTLE are ignored.
- Counters saturate at 2^CNT_W-1 with no wrap. err_count never exceeds vec_count.
- Simultaneous events:
  - clear has priority over CHECK updates in the same cycle; all state clears and the FSM goes to IDLE.
  - en falling during SETTLE or CHECK aborts to IDLE with no count; the CHECK-cycle update is suppressed.
- Reset mid-operation clears everything immediately (asynchronous), including sticky flags.

Decomposition:
- Package half_adder_pkg holds:
  - the state encoding (IDLE=2'd0, SETTLE=2'd1, CHECK=2'd2, WAIT=2'd3);
  - the constant width of first_err_vec (4);
  - an expected-result function returning {a^b, a&b}.
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, q) is instantiated twice, for vec_count and err_count.

Test Plan:
- Correct DUT, vectors 00,01,10,11, each held 4 cycles, SETTLE=2 -> vec_count=4, err_count=0, err_flag=0, cov=4'b1111, all_covered=1.
- Stuck-at-0 carry, vector 11 -> err_count=1, err_flag=1, first_err_vec=4'b1110, first_err_valid=1.
- Then force sum wrong on vector 01 -> err_count=2, first_err_vec still 4'b1110.
- Input toggles every cycle for 10 cycles (never stable 2 cycles) -> no check_pulse, vec_count=0.
- Then hold 10 for 5 cycles -> exactly one check_pulse, 2 cycles after the hold begins.
- CNT_W=3, 9 stable vectors -> vec_count saturates at 7.
- clear asserted in the same cycle as a CHECK -> vec_count=0, cov=0.
- rst pulsed mid-SETTLE -> all outputs 0 immediately, FSM in IDLE.
- en dropped during SETTLE -> no count.
- en re-raised -> the current vector is checked SETTLE cycles later.
